// File: rtl/memory_access_stage.sv
// MEM pipeline stage: wait-stated word-addressed data memory with freeze back-pressure
// and a registered MEM/WB output bundle that carries a bubble while frozen.
module memory_access_stage #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writebackEnabled_in,
  input  logic        memoryReadEnabled_in,
  input  logic        memoryWriteEnabled_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] valRm_in,
  input  logic [3:0]  destination_in,
  output logic        freeze,
  output logic        writebackEnabled,
  output logic        memoryReadEnabled,
  output logic [31:0] aluResult,
  output logic [31:0] memoryData,
  output logic [3:0]  destination
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_mem_op;
  logic            w_is_load;
  logic            w_in_range;
  logic [31:0]     w_word;
  logic [IdxW-1:0] w_index;

  assign w_mem_op   = memoryReadEnabled_in | memoryWriteEnabled_in;
  // A combined read+write request is executed as a store only.
  assign w_is_load  = memoryReadEnabled_in & ~memoryWriteEnabled_in;
  assign w_word     = (aluResult_in - 32'(BASE_ADDR)) >> 2;
  assign w_in_range = (aluResult_in >= 32'(BASE_ADDR)) && (w_word < 32'(DEPTH_WORDS));
  assign w_index    = w_word[IdxW-1:0];

  assign freeze = rst && ((r_state == StWait) || ((r_state == StIdle) && w_mem_op));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= StIdle;
      r_cnt             <= '0;
      writebackEnabled  <= 1'b0;
      memoryReadEnabled <= 1'b0;
      aluResult         <= '0;
      memoryData        <= '0;
      destination       <= '0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Bubble by default; only non-frozen cycles overwrite it below.
      writebackEnabled  <= 1'b0;
      memoryReadEnabled <= 1'b0;
      aluResult         <= '0;
      memoryData        <= '0;
      destination       <= '0;
      case (r_state)
        StIdle: begin
          if (w_mem_op) begin
            r_state <= StWait;
            r_cnt   <= 4'(WAIT_CYCLES);
          end else begin
            writebackEnabled  <= writebackEnabled_in;
            memoryReadEnabled <= memoryReadEnabled_in;
            aluResult         <= aluResult_in;
            destination       <= destination_in;
          end
        end
        StWait: begin
          if (r_cnt == 4'd1) begin
            r_state <= StDone;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: begin
          r_state           <= StIdle;
          writebackEnabled  <= writebackEnabled_in;
          memoryReadEnabled <= w_is_load;
          aluResult         <= aluResult_in;
          destination       <= destination_in;
          memoryData        <= (w_is_load && w_in_range) ? r_mem[w_index] : '0;
          if (memoryWriteEnabled_in && w_in_range) begin
            r_mem[w_index] <= valRm_in;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: reset, pass-through, store/load timing,
// range checks, reset abort and back-to-back accesses.
module tb_memory_access_stage;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned WC    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_in = 1'b0, rd_in = 1'b0, wr_in = 1'b0;
  logic [31:0] alu_in = '0, val_in = '0;
  logic [3:0]  dest_in = '0;
  logic        freeze, wb_o, rd_o;
  logic [31:0] alu_o, md_o;
  logic [3:0]  dest_o;

  int unsigned n_vectors = 0;
  int unsigned n_miscompares = 0;

  memory_access_stage #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .writebackEnabled_in  (wb_in),
    .memoryReadEnabled_in (rd_in),
    .memoryWriteEnabled_in(wr_in),
    .aluResult_in         (alu_in),
    .valRm_in             (val_in),
    .destination_in       (dest_in),
    .freeze               (freeze),
    .writebackEnabled     (wb_o),
    .memoryReadEnabled    (rd_o),
    .aluResult            (alu_o),
    .memoryData           (md_o),
    .destination          (dest_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
    wb_in = wb; rd_in = rd; wr_in = wr; alu_in = alu; val_in = val; dest_in = dest;
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check_eq(tag, alu_o | md_o | {26'b0, wb_o, rd_o, dest_o}, 32'h0);
  endtask

  // Runs one full access from IDLE and checks freeze, bubbles and the delivered result.
  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] val, input logic [31:0] exp_md, input string tag);
    logic [3:0] d;
    d = addr[5:2];
    drive(rd, rd, wr, addr, val, d);
    check_eq({tag, ".frz_idle"}, {31'b0, freeze}, 32'd1);
    for (int k = 0; k < int'(WC); k++) begin
      step();
      check_eq({tag, ".frz_wait"}, {31'b0, freeze}, 32'd1);
      check_bubble({tag, ".bubble_wait"});
    end
    step();
    check_eq({tag, ".frz_done"}, {31'b0, freeze}, 32'd0);
    check_bubble({tag, ".bubble_done"});
    step();
    check_eq({tag, ".alu"}, alu_o, addr);
    check_eq({tag, ".mdata"}, md_o, exp_md);
    check_eq({tag, ".ctl"}, {26'b0, wb_o, rd_o, dest_o}, {26'b0, rd, rd & ~wr, d});
  endtask

  initial begin
    // Reset with arbitrary, op-requesting inputs.
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h99, 4'd7);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst.freeze", {31'b0, freeze}, 32'd0);
      check_bubble("rst.outs");
      step();
    end
    check_eq("rst.freeze_end", {31'b0, freeze}, 32'd0);
    check_bubble("rst.outs_end");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    rst = 1'b1;

    // Non-memory pass-through.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'd5);
    check_eq("alu_op.freeze_pre", {31'b0, freeze}, 32'd0);
    step();
    check_eq("alu_op.freeze_post", {31'b0, freeze}, 32'd0);
    check_eq("alu_op.alu", alu_o, 32'h0000_1234);
    check_eq("alu_op.mdata", md_o, 32'h0);
    check_eq("alu_op.ctl", {26'b0, wb_o, rd_o, dest_o}, {26'b0, 1'b1, 1'b0, 4'd5});

    // Store then load the same word; load right after store (back-to-back).
    mem_op(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 32'h0, "st1028");
    mem_op(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEAD_BEEF, "ld1028");
    // Read+write together acts as a store.
    mem_op(1'b1, 1'b1, 32'd1036, 32'h1357_9BDF, 32'h0, "rw1036");
    mem_op(1'b1, 1'b0, 32'd1036, 32'h0, 32'h1357_9BDF, "ld1036");
    // Below base address.
    mem_op(1'b1, 1'b0, 32'd1020, 32'h0, 32'h0, "ld1020");

    // Reset clears memory, then out-of-range store must leave every word at 0.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    rst = 1'b0;
    #1;
    check_bubble("rst2.outs");
    step();
    rst = 1'b1;
    mem_op(1'b0, 1'b1, BASE + 4 * DEPTH, 32'h55, 32'h0, "st_oor");
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_op(1'b1, 1'b0, BASE + 4 * i, 32'h0, 32'h0, "scan");
    end

    // Reset during the second WAIT cycle aborts the store.
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'hA5A5_A5A5, 4'd0);
    step();
    step();
    check_eq("abort.frz_wait2", {31'b0, freeze}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("abort.frz_rst", {31'b0, freeze}, 32'd0);
    check_bubble("abort.outs");
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    rst = 1'b1;
    mem_op(1'b1, 1'b0, 32'd1024, 32'h0, 32'h0, "abort.ld1024");

    // Back-to-back loads delivered in order, one freeze-free DONE cycle between windows.
    mem_op(1'b0, 1'b1, 32'd1024, 32'h1111_2222, 32'h0, "st1024");
    mem_op(1'b0, 1'b1, 32'd1032, 32'h3333_4444, 32'h0, "st1032");
    mem_op(1'b1, 1'b0, 32'd1024, 32'h0, 32'h1111_2222, "b2b.ld1024");
    mem_op(1'b1, 1'b0, 32'd1032, 32'h0, 32'h3333_4444, "b2b.ld1032");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    check_eq("end.freeze", {31'b0, freeze}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: data memory depth in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 1024: byte address mapped to word 0.
REQ-003 Parameter WAIT_CYCLES, default 3, legal range 1..15: memory access wait states.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 writebackEnabled_in  in  1  EXE-stage writeback request.
REQ-007 memoryReadEnabled_in  in  1  EXE-stage load.
REQ-008 memoryWriteEnabled_in  in  1  EXE-stage store.
REQ-009 aluResult_in  in  32  ALU result; byte address for loads and stores.
REQ-010 valRm_in  in  32  store data.
REQ-011 destination_in  in  4  destination register index.
REQ-012 freeze  out  1  stall request to IF/ID/EXE stages and their registers; combinational.
REQ-013 writebackEnabled  out  1  registered writeback request to WB.
REQ-014 memoryReadEnabled  out  1  registered load flag to WB (selects memoryData).
REQ-015 aluResult  out  32  registered ALU result.
REQ-016 memoryData  out  32  registered load data.
REQ-017 destination  out  4  registered destination index.

Function
REQ-018 Memory op: memoryReadEnabled_in or memoryWriteEnabled_in is high.
REQ-019 Word index = (aluResult_in - BASE_ADDR) >> 2; bits [1:0] ignored.
REQ-020 In-range: aluResult_in >= BASE_ADDR and word index < DEPTH_WORDS.
REQ-021 FSM states are IDLE, WAIT and DONE.
REQ-022 IDLE with memory op: freeze=1; load counter with WAIT_CYCLES; next state WAIT.
REQ-023 IDLE without memory op: freeze=0; output register captures all inputs at the edge; memoryData is set to 0.
REQ-024 WAIT: freeze=1; when counter==1 go to DONE, else decrement the counter; WAIT lasts exactly WAIT_CYCLES cycles.
REQ-025 DONE: freeze=0; inputs are ignored for op detection; next state IDLE unconditionally.
REQ-026 DONE edge, in-range store: mem[index] <= valRm_in.
REQ-027 DONE edge, load: memoryData <= mem[index] when in-range, else 0.
REQ-028 DONE edge: output register captures writebackEnabled_in, memoryReadEnabled_in, aluResult_in and destination_in.
REQ-029 Freeze per memory op = WAIT_CYCLES+1 consecutive cycles; op result valid at outputs WAIT_CYCLES+2 edges after it is first presented.
REQ-030 On every edge where freeze=1, the output register loads a bubble: writebackEnabled=0, memoryReadEnabled=0, other outputs 0.
REQ-031 Upstream holds inputs stable while freeze=1; the block does not latch inputs before DONE.
REQ-032 Out-of-range store: dropped, memory unchanged.
REQ-033 Read and write both high: treated as store; memoryReadEnabled output forced 0; memoryData=0.
REQ-034 Back-to-back memory ops: the second op is detected in IDLE the cycle after DONE, so one non-frozen cycle separates the freeze windows.
REQ-035 A load following a store to the same word returns the stored value.

Reset
REQ-036 rst=0 immediately forces state IDLE, counter 0, freeze 0, and all registered outputs 0, independent of clk.
REQ-037 rst=0 clears all memory words to 0.
REQ-038 Reset asserted during WAIT aborts the access: no memory write and no output capture.
REQ-039 After rst rises, the first edge evaluates the inputs in IDLE.

Verification
REQ-040 Reset: drive rst=0 for 2 cycles with arbitrary inputs -> freeze=0 and all outputs 0 throughout.
REQ-041 Non-memory op: aluResult_in=0x00001234, writebackEnabled_in=1, destination_in=5 -> next edge gives aluResult=0x1234, destination=5, writebackEnabled=1, memoryData=0; freeze never 1.
REQ-042 Store then load (WAIT_CYCLES=3): store 0xDEADBEEF to 1028 -> freeze 1 for 4 cycles, then 0 for DONE; then load from 1028 -> after 5 edges memoryData=0xDEADBEEF, memoryReadEnabled=1; during the freeze the outputs show a bubble.
REQ-043 Out-of-range: load from 1020 -> memoryData=0; store 0x55 to 1024+4*DEPTH_WORDS, then read all words -> every word still 0.
REQ-044 Reset mid-access: store 0xA5A5A5A5 to 1024, assert rst in the second WAIT cycle -> freeze 0 immediately; load from 1024 after reset returns 0.
REQ-045 Back-to-back loads to 1024 and 1032 -> two 4-cycle freeze windows separated by exactly one freeze=0 cycle; results delivered in order.
